// File: rtl/ps2_pad_responder.sv
// ps2_pad_responder: device-side PS2 pad model answering a host poll.
// Define PS2_PAD_ANALOG_EN for the 9-byte analog frame; default is digital.
module ps2_pad_responder #(
  parameter int ACK_DELAY   = 40,
  parameter int ACK_WIDTH   = 80,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scs,
  input  logic        sclk,
  input  logic        cmd,
  output logic        sdo,
  output logic        ack_n,
  input  logic [15:0] buttons,
  input  logic [7:0]  stick_rx,
  input  logic [7:0]  stick_ry,
  input  logic [7:0]  stick_lx,
  input  logic [7:0]  stick_ly,
  output logic        busy,
  output logic        frame_done,
  output logic        bad_cmd
);

`ifdef PS2_PAD_ANALOG_EN
  localparam logic [7:0] PAD_ID = 8'h73;
  localparam logic [3:0] LAST   = 4'd8;
`else
  localparam logic [7:0] PAD_ID = 8'h41;
  localparam logic [3:0] LAST   = 4'd4;
`endif

  localparam logic [15:0] DLY_LD = 16'(ACK_DELAY - 1);
  localparam logic [15:0] WID_LD = 16'(ACK_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_WAIT,
    A_LOW
  } ack_t;

  logic [SYNC_STAGES-1:0] scs_q, sclk_q, cmd_q;
  logic scs_s, sclk_s, cmd_s;
  logic scs_d, sclk_d;
  logic scs_fall, scs_rise, sclk_fall, sclk_rise;

  state_t      state, state_n;
  ack_t        ack_st, ack_st_n;
  logic [15:0] ack_cnt, ack_cnt_n;
  logic [3:0]  byte_idx, byte_n, byte_inc;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  tx, tx_n, resp_byte, rx_full;
  logic [6:0]  rx, rx_n;
  logic        sdo_n, ack_n_n, busy_n, fd_n, bad_n;
  logic        snap_ld;
  logic [15:0] btn_snap;

  // Input synchronizers plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scs_q  <= '1;
      sclk_q <= '1;
      cmd_q  <= '1;
      scs_d  <= 1'b1;
      sclk_d <= 1'b1;
    end else begin
      scs_q  <= {scs_q[SYNC_STAGES-2:0], scs};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cmd_q  <= {cmd_q[SYNC_STAGES-2:0], cmd};
      scs_d  <= scs_s;
      sclk_d <= sclk_s;
    end
  end

  assign scs_s     = scs_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cmd_s     = cmd_q[SYNC_STAGES-1];
  assign scs_fall  = scs_d & ~scs_s;
  assign scs_rise  = ~scs_d & scs_s;
  assign sclk_fall = sclk_d & ~sclk_s;
  assign sclk_rise = ~sclk_d & sclk_s;

  assign byte_inc = (byte_idx == 4'hF) ? 4'hF : byte_idx + 4'd1;
  assign rx_full  = {cmd_s, rx};

`ifdef PS2_PAD_ANALOG_EN
  logic [7:0] rx_snap, ry_snap, lx_snap, ly_snap;

  // Frame-coherent snapshot of buttons and sticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_snap <= '0;
      rx_snap  <= '0;
      ry_snap  <= '0;
      lx_snap  <= '0;
      ly_snap  <= '0;
    end else if (snap_ld) begin
      btn_snap <= buttons;
      rx_snap  <= stick_rx;
      ry_snap  <= stick_ry;
      lx_snap  <= stick_lx;
      ly_snap  <= stick_ly;
    end
  end
`else
  logic unused_sticks;
  assign unused_sticks = ^{stick_rx, stick_ry, stick_lx, stick_ly};

  // Frame-coherent snapshot of buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_snap <= '0;
    end else if (snap_ld) begin
      btn_snap <= buttons;
    end
  end
`endif

  // Response byte for the next byte slot
  always_comb begin
    resp_byte = 8'hFF;
    case (byte_inc)
      4'd1: resp_byte = PAD_ID;
      4'd2: resp_byte = 8'h5A;
      4'd3: resp_byte = ~btn_snap[7:0];
      4'd4: resp_byte = ~btn_snap[15:8];
`ifdef PS2_PAD_ANALOG_EN
      4'd5: resp_byte = rx_snap;
      4'd6: resp_byte = ry_snap;
      4'd7: resp_byte = lx_snap;
      4'd8: resp_byte = ly_snap;
`endif
      default: resp_byte = 8'hFF;
    endcase
  end

  // Frame state, shift registers and ack timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ack_st     <= A_IDLE;
      ack_cnt    <= '0;
      byte_idx   <= '0;
      bit_idx    <= '0;
      tx         <= 8'hFF;
      rx         <= '0;
      sdo        <= 1'b1;
      ack_n      <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bad_cmd    <= 1'b0;
    end else begin
      state      <= state_n;
      ack_st     <= ack_st_n;
      ack_cnt    <= ack_cnt_n;
      byte_idx   <= byte_n;
      bit_idx    <= bit_n;
      tx         <= tx_n;
      rx         <= rx_n;
      sdo        <= sdo_n;
      ack_n      <= ack_n_n;
      busy       <= busy_n;
      frame_done <= fd_n;
      bad_cmd    <= bad_n;
    end
  end

  // Next-state: ack timer first, then frame control overrides it
  always_comb begin
    state_n   = state;
    ack_st_n  = ack_st;
    ack_cnt_n = ack_cnt;
    byte_n    = byte_idx;
    bit_n     = bit_idx;
    tx_n      = tx;
    rx_n      = rx;
    sdo_n     = sdo;
    ack_n_n   = ack_n;
    busy_n    = busy;
    fd_n      = 1'b0;
    bad_n     = 1'b0;
    snap_ld   = 1'b0;

    unique case (ack_st)
      A_WAIT: begin
        if (ack_cnt == '0) begin
          ack_n_n   = 1'b0;
          ack_st_n  = A_LOW;
          ack_cnt_n = WID_LD;
        end else begin
          ack_cnt_n = ack_cnt - 16'd1;
        end
      end
      A_LOW: begin
        if (ack_cnt == '0) begin
          ack_n_n  = 1'b1;
          ack_st_n = A_IDLE;
        end else begin
          ack_cnt_n = ack_cnt - 16'd1;
        end
      end
      default: ;
    endcase

    if (scs_rise) begin
      state_n  = S_IDLE;
      sdo_n    = 1'b1;
      ack_n_n  = 1'b1;
      ack_st_n = A_IDLE;
      busy_n   = 1'b0;
      byte_n   = '0;
      bit_n    = '0;
      fd_n     = (state == S_XFER) && (byte_idx > LAST) &&
                 (bit_idx == 3'd0);
    end else begin
      unique case (state)
        S_IDLE: begin
          if (scs_fall) begin
            state_n = S_XFER;
            snap_ld = 1'b1;
            byte_n  = '0;
            bit_n   = '0;
            busy_n  = 1'b1;
            tx_n    = 8'hFF;
            sdo_n   = 1'b1;
          end
        end
        S_XFER: begin
          if (sclk_fall) begin
            sdo_n = tx[bit_idx];
          end else if (sclk_rise) begin
            rx_n  = {cmd_s, rx[6:1]};
            bit_n = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if ((byte_idx == 4'd0 && rx_full != 8'h01) ||
                  (byte_idx == 4'd1 && rx_full != 8'h42)) begin
                bad_n    = 1'b1;
                state_n  = S_IGNORE;
                sdo_n    = 1'b1;
                ack_n_n  = 1'b1;
                ack_st_n = A_IDLE;
              end else begin
                byte_n = byte_inc;
                tx_n   = resp_byte;
                if (byte_idx < LAST) begin
                  ack_st_n  = A_WAIT;
                  ack_cnt_n = DLY_LD;
                  ack_n_n   = 1'b1;
                end
              end
            end
          end
        end
        S_IGNORE: begin
          sdo_n   = 1'b1;
          ack_n_n = 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule
